// File: rtl/render_reset_sequencer_if.sv
// render_reset_sequencer_if: framebuffer clear write port (valid/ready)
interface render_reset_sequencer_if #(
    parameter int FB_ADDR_W = 17,
    parameter int FB_DATA_W = 12
);
    logic                 fb_clr_valid;
    logic                 fb_clr_ready;
    logic [FB_ADDR_W-1:0] fb_clr_addr;
    logic [FB_DATA_W-1:0] fb_clr_data;

    modport master (output fb_clr_valid, output fb_clr_addr, output fb_clr_data, input fb_clr_ready);
    modport slave  (input fb_clr_valid, input fb_clr_addr, input fb_clr_data, output fb_clr_ready);
endinterface

// File: rtl/render_reset_sequencer.sv
// render_reset_sequencer: WIPE_ALL soft reset - drain, hold stage resets, clear framebuffer, staggered release
module render_reset_sequencer #(
    parameter int                   NUM_STAGES    = 4,
    parameter int                   HOLD_CYCLES   = 16,
    parameter int                   STAGE_GAP     = 4,
    parameter int                   DRAIN_TIMEOUT = 1024,
    parameter int                   FB_ADDR_W     = 17,
    parameter int                   FB_DEPTH      = 76800,
    parameter int                   FB_DATA_W     = 12,
    parameter logic [FB_DATA_W-1:0] CLEAR_VALUE   = '0
) (
    input  logic                  clk_render,
    input  logic                  rst_render_locked,
    input  logic                  soft_reset_req,
    input  logic                  pipe_idle,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  drain_timeout,
    render_reset_sequencer_if.master fb
);
    localparam int CNT_MAX = (DRAIN_TIMEOUT > HOLD_CYCLES) ?
                             ((DRAIN_TIMEOUT > STAGE_GAP) ? DRAIN_TIMEOUT : STAGE_GAP) :
                             ((HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {IDLE, DRAIN, ASSERT, CLEAR, RELEASE, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [FB_ADDR_W-1:0]  addr, addr_nxt;
    logic [NUM_STAGES-1:0] rst_nxt;
    logic                  to_nxt, pending, pend_nxt, req_q, req;

    assign req              = soft_reset_req & ~req_q;
    assign busy             = state != IDLE;
    assign seq_done         = state == DONE;
    assign fb.fb_clr_valid  = state == CLEAR;
    assign fb.fb_clr_addr   = addr;
    assign fb.fb_clr_data   = CLEAR_VALUE;

    // Reset lands in RELEASE with all stages held, so power-up gets the staggered release without a clear
    always_ff @(posedge clk_render or posedge rst_render_locked) begin
        if (rst_render_locked) begin
            state         <= RELEASE;
            cnt           <= '0;
            idx           <= IW'(NUM_STAGES - 1);
            addr          <= '0;
            stage_rst     <= '1;
            drain_timeout <= 1'b0;
            pending       <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            idx           <= idx_nxt;
            addr          <= addr_nxt;
            stage_rst     <= rst_nxt;
            drain_timeout <= to_nxt;
            pending       <= pend_nxt;
            req_q         <= soft_reset_req;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        addr_nxt  = addr;
        rst_nxt   = stage_rst;
        to_nxt    = drain_timeout;
        pend_nxt  = pending | (req & (state != IDLE));
        case (state)
            IDLE: begin
                rst_nxt = '0;
                if (req) begin
                    state_nxt = DRAIN;
                    to_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            DRAIN: begin
                cnt_nxt = cnt + 1'b1;
                // idle wins over the timeout when both happen in the same cycle
                if (pipe_idle || cnt == CW'(DRAIN_TIMEOUT - 1)) begin
                    state_nxt = ASSERT;
                    cnt_nxt   = '0;
                    rst_nxt   = '1;
                    to_nxt    = drain_timeout | ~pipe_idle;
                end
            end
            ASSERT: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                end
            end
            CLEAR: begin
                if (fb.fb_clr_ready) begin
                    addr_nxt = addr + 1'b1;
                    if (addr == FB_ADDR_W'(FB_DEPTH - 1)) begin
                        state_nxt = RELEASE;
                        addr_nxt  = addr;
                        cnt_nxt   = '0;
                        idx_nxt   = IW'(NUM_STAGES - 1);
                    end
                end
            end
            RELEASE: begin
                if (cnt == '0) rst_nxt[idx] = 1'b0;
                if (cnt == '0 && idx == '0) state_nxt = DONE;
                else if (cnt == CW'(STAGE_GAP - 1)) begin
                    cnt_nxt = '0;
                    idx_nxt = idx - 1'b1;
                end else cnt_nxt = cnt + 1'b1;
            end
            DONE: begin
                pend_nxt  = 1'b0;
                state_nxt = (pending | req) ? DRAIN : IDLE;
                if (pending | req) begin
                    to_nxt  = 1'b0;
                    cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
